alu_dispatch: RTL and testbench
===============================

Name: alu_dispatch

Overview:
- Upstream issue stage for the ALU.
- Accepts one decoded RV32I OP / OP-IMM / BRANCH instruction plus operand values and decodes it into the ALU's 5-bit op and A/B operands.
- Runs the ALU's available/busy handshake, then returns the result, branch decision and branch target to the execute sequencer.
- Catches illegal encodings locally and never issues them to the ALU.

Parameters:
- TIMEOUT_CYCLES, 15: max cycles in ISSUE+WAIT before watchdog fault (used only with the optional feature).

Ports:
- clk  in  1  clock
- reset  in  1  asynchronous reset, active-high
- start  in  1  request; sampled only while ready=1
- ready  out  1  high in IDLE
- instr  in  32  instruction word, sampled with start
- pc  in  32  instruction address, sampled with start
- rs1_data  in  32  rs1 value, sampled with start
- rs2_data  in  32  rs2 value, sampled with start
- done  out  1  one-cycle completion pulse
- result  out  32  ALU result; 0 for branches
- branch_taken  out  1  valid with done
- branch_target  out  32  pc + B-immediate, valid with done
- fault  out  1  illegal instruction / ALU fault / timeout, valid with done
- alu_available  out  1  to ALU
- alu_op  out  5  to ALU
- alu_in_a  out  32  to ALU
- alu_in_b  out  32  to ALU
- alu_out  in  32  from ALU
- alu_busy  in  1  from ALU
- alu_fault  in  1  from ALU

Behaviour:
- Reset (async, any state): state=IDLE; every output 0 except ready=1; in-flight operation abandoned, alu_available drops immediately.
- Op encoding is {is_branch, f7b5, funct3}:
  - OP: f7b5 = instr[30].
  - OP-IMM: f7b5 = instr[30] only for funct3=101; 0 otherwise.
  - BRANCH: is_branch=1, f7b5=0.
- Operands:
  - alu_in_a = rs1.
  - alu_in_b = rs2 for OP and BRANCH; sign-extended I-immediate for OP-IMM.
- Local illegal encodings:
  - Opcode not in {0010011, 0110011, 1100011}.
  - OP with funct7 not in {0000000, 0100000}.
  - OP with funct7=0100000 and funct3 not in {000, 101}.
  - SLLI with imm[11:5]≠0.
  - SRLI/SRAI with imm[11:5] not in {0000000, 0100000}.
  - BRANCH with funct3 in {010, 011}.
- branch_target = pc + sign-extended B-immediate, computed with a local adder mod 2^32.
- FSM states:
  - IDLE: ready=1. On start, register op/operands/target.
    - Legal instruction → ISSUE.
    - Illegal instruction → DONE with fault=1; ALU is never touched.
  - ISSUE: alu_available=1; inputs held stable. alu_busy=1 → WAIT.
  - WAIT: alu_available=1. alu_busy=0 → DONE, registering:
    - result = alu_out (branches: 0);
    - branch_taken = is_branch & alu_out[0];
    - fault = alu_fault.
  - DONE: done=1 for exactly one cycle; alu_available=0, which guarantees the ALU's internal start flag clears. Then → IDLE.
- Timing: start sampled at edge E0 → alu_available high after E0 → ALU busy after E1 → WAIT after E2 → done after E3. The illegal path gives done after E0.
- Holding rules:
  - start while not ready: ignored, no queuing.
  - result, branch_taken, branch_target and fault hold their values until the next done.
  - done=0 except in DONE.
- Back-to-back: start in the IDLE cycle immediately after DONE is accepted.

Optional Feature:
- Macro: ALU_DISPATCH_TIMEOUT_EN.
- Enabled:
  - A counter clears on entry to ISSUE and increments each cycle in ISSUE/WAIT.
  - On reaching TIMEOUT_CYCLES → DONE with fault=1, result=0, branch_taken=0, alu_available dropped.
- Disabled: no counter; the FSM waits indefinitely.

Decomposition:
- Package alu_pkg:
  - RV opcode constants;
  - alu_op_t (5-bit) with ADD, SUB, SLL, SLT, SLTU, XOR, SRL, SRA, OR, AND, BEQ, BNE, BLT, BGE, BLTU, BGEU encodings;
  - dispatch_state_t enum.
- One natural combinational sub-module, alu_decode: instr → op, use_imm, imm, branch_imm, illegal. The FSM, registers and target adder stay in alu_dispatch.

Test Plan:
- ADD (0x00208033), rs1=5, rs2=7 → done 4 cycles after start; result=12, fault=0, alu_op=00000.
- SRAI imm=0x404 (shamt 4), rs1=0x80000000 → alu_op=01101, alu_in_b=0x404, result=0xF8000000.
- BLT, rs1=−1, rs2=1, pc=0x100, imm=+16 → branch_taken=1, branch_target=0x110, result=0.
- OP with funct7=0000001 → done the cycle after start, fault=1, alu_available never asserted.
- Reset asserted in WAIT → alu_available=0 and ready=1 immediately; next ADD completes correctly.
- TIMEOUT_EN, TIMEOUT_CYCLES=4, alu_busy stuck 0 → done with fault=1 exactly 4 cycles after ISSUE entry.

Source files
------------

// File: rtl/alu_pkg.sv
// Shared opcode constants, ALU operation encodings and dispatch FSM states.
package alu_pkg;

   localparam logic [6:0] OpcOpImm  = 7'b0010011;
   localparam logic [6:0] OpcOp     = 7'b0110011;
   localparam logic [6:0] OpcBranch = 7'b1100011;

   // Encoding is {is_branch, f7b5, funct3}
   typedef enum logic [4:0] {
      AluAdd  = 5'b00000,
      AluSub  = 5'b01000,
      AluSll  = 5'b00001,
      AluSlt  = 5'b00010,
      AluSltu = 5'b00011,
      AluXor  = 5'b00100,
      AluSrl  = 5'b00101,
      AluSra  = 5'b01101,
      AluOr   = 5'b00110,
      AluAnd  = 5'b00111,
      AluBeq  = 5'b10000,
      AluBne  = 5'b10001,
      AluBlt  = 5'b10100,
      AluBge  = 5'b10101,
      AluBltu = 5'b10110,
      AluBgeu = 5'b10111
   } alu_op_t;

   typedef enum logic [1:0] {
      StIdle  = 2'b00,
      StIssue = 2'b01,
      StWait  = 2'b10,
      StDone  = 2'b11
   } dispatch_state_t;

endpackage

// File: rtl/alu_decode.sv
// Combinational RV32I OP / OP-IMM / BRANCH decoder: ALU op, immediates and legality.
module alu_decode
   import alu_pkg::*;
(
   input  logic [31:0] instr,
   output alu_op_t     op,
   output logic        use_imm,
   output logic [31:0] imm,
   output logic [31:0] branch_imm,
   output logic        illegal
);

   logic [6:0] opcode;
   logic [6:0] funct7;
   logic [2:0] funct3;
   logic [4:0] op_raw;
   logic       unused_rs_fields;

   assign opcode     = instr[6:0];
   assign funct3     = instr[14:12];
   assign funct7     = instr[31:25];
   assign imm        = {{20{instr[31]}}, instr[31:20]};
   assign branch_imm = {{20{instr[31]}}, instr[7], instr[30:25], instr[11:8], 1'b0};
   assign unused_rs_fields = ^instr[19:15];

   always_comb begin
      op_raw  = 5'b00000;
      use_imm = 1'b0;
      illegal = 1'b0;
      case (opcode)
         OpcOp: begin
            op_raw = {1'b0, instr[30], funct3};
            if (funct7 == 7'b0100000) begin
               illegal = (funct3 != 3'b000) && (funct3 != 3'b101);
            end else begin
               illegal = (funct7 != 7'b0000000);
            end
         end
         OpcOpImm: begin
            use_imm = 1'b1;
            op_raw  = {1'b0, (funct3 == 3'b101) ? instr[30] : 1'b0, funct3};
            if (funct3 == 3'b001) begin
               illegal = (funct7 != 7'b0000000);
            end else if (funct3 == 3'b101) begin
               illegal = (funct7 != 7'b0000000) && (funct7 != 7'b0100000);
            end
         end
         OpcBranch: begin
            op_raw  = {2'b10, funct3};
            illegal = (funct3 == 3'b010) || (funct3 == 3'b011);
         end
         default: illegal = 1'b1;
      endcase
      // Illegal encodings may form codes outside alu_op_t; never cast those.
      op = illegal ? AluAdd : alu_op_t'(op_raw);
   end

endmodule

// File: rtl/alu_dispatch.sv
// ALU issue stage: decode, available/busy handshake, result and branch return.
// Optional watchdog enabled by defining ALU_DISPATCH_TIMEOUT_EN.
module alu_dispatch
   import alu_pkg::*;
#(
   parameter int unsigned TIMEOUT_CYCLES = 15
) (
   input  logic        clk,
   input  logic        reset,
   input  logic        start,
   output logic        ready,
   input  logic [31:0] instr,
   input  logic [31:0] pc,
   input  logic [31:0] rs1_data,
   input  logic [31:0] rs2_data,
   output logic        done,
   output logic [31:0] result,
   output logic        branch_taken,
   output logic [31:0] branch_target,
   output logic        fault,
   output logic        alu_available,
   output logic [4:0]  alu_op,
   output logic [31:0] alu_in_a,
   output logic [31:0] alu_in_b,
   input  logic [31:0] alu_out,
   input  logic        alu_busy,
   input  logic        alu_fault
);

   dispatch_state_t state_q, state_d;
   alu_op_t         op_q, op_d;
   logic [31:0]     a_q, a_d, b_q, b_d, target_q, target_d;
   logic [31:0]     result_q, result_d, target_out_q, target_out_d;
   logic            taken_q, taken_d, fault_q, fault_d;

   alu_op_t     dec_op;
   logic        dec_use_imm, dec_illegal;
   logic [31:0] dec_imm, dec_bimm, target_calc;

   alu_decode u_decode (
      .instr      (instr),
      .op         (dec_op),
      .use_imm    (dec_use_imm),
      .imm        (dec_imm),
      .branch_imm (dec_bimm),
      .illegal    (dec_illegal)
   );

   assign target_calc = pc + dec_bimm;

`ifdef ALU_DISPATCH_TIMEOUT_EN
   logic [31:0] cnt_q, cnt_d;
`else
   localparam int unsigned unused_timeout = TIMEOUT_CYCLES;
`endif

   always_comb begin
      state_d      = state_q;
      op_d         = op_q;
      a_d          = a_q;
      b_d          = b_q;
      target_d     = target_q;
      result_d     = result_q;
      taken_d      = taken_q;
      target_out_d = target_out_q;
      fault_d      = fault_q;
      unique case (state_q)
         StIdle: begin
            if (start) begin
               if (dec_illegal) begin
                  state_d      = StDone;
                  result_d     = '0;
                  taken_d      = 1'b0;
                  fault_d      = 1'b1;
                  target_out_d = target_calc;
               end else begin
                  state_d  = StIssue;
                  op_d     = dec_op;
                  a_d      = rs1_data;
                  b_d      = dec_use_imm ? dec_imm : rs2_data;
                  target_d = target_calc;
               end
            end
         end
         StIssue: begin
            if (alu_busy) state_d = StWait;
         end
         StWait: begin
            if (!alu_busy) begin
               state_d      = StDone;
               result_d     = op_q[4] ? '0 : alu_out;
               taken_d      = op_q[4] & alu_out[0];
               fault_d      = alu_fault;
               target_out_d = target_q;
            end
         end
         StDone:  state_d = StIdle;
         default: state_d = StIdle;
      endcase
`ifdef ALU_DISPATCH_TIMEOUT_EN
      cnt_d = '0;
      if (state_q == StIssue || state_q == StWait) begin
         cnt_d = cnt_q + 32'd1;
         // A normal completion in the same cycle wins over the watchdog.
         if (state_d != StDone && cnt_q == TIMEOUT_CYCLES - 1) begin
            state_d      = StDone;
            result_d     = '0;
            taken_d      = 1'b0;
            fault_d      = 1'b1;
            target_out_d = target_q;
         end
      end
`endif
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q      <= StIdle;
         op_q         <= AluAdd;
         a_q          <= '0;
         b_q          <= '0;
         target_q     <= '0;
         result_q     <= '0;
         taken_q      <= 1'b0;
         target_out_q <= '0;
         fault_q      <= 1'b0;
      end else begin
         state_q      <= state_d;
         op_q         <= op_d;
         a_q          <= a_d;
         b_q          <= b_d;
         target_q     <= target_d;
         result_q     <= result_d;
         taken_q      <= taken_d;
         target_out_q <= target_out_d;
         fault_q      <= fault_d;
      end
   end

`ifdef ALU_DISPATCH_TIMEOUT_EN
   always_ff @(posedge clk or posedge reset) begin
      if (reset) cnt_q <= '0;
      else       cnt_q <= cnt_d;
   end
`endif

   assign ready         = (state_q == StIdle);
   assign done          = (state_q == StDone);
   assign alu_available = (state_q == StIssue) || (state_q == StWait);
   assign alu_op        = op_q;
   assign alu_in_a      = a_q;
   assign alu_in_b      = b_q;
   assign result        = result_q;
   assign branch_taken  = taken_q;
   assign branch_target = target_out_q;
   assign fault         = fault_q;

endmodule

// File: tb/tb_alu_dispatch.sv
// Directed bench for alu_dispatch with a behavioural ALU and a cycle-level expectation model.
module tb_alu_dispatch;

   localparam int unsigned TO = 4;

   logic        clk = 1'b0;
   logic        reset, start;
   logic [31:0] instr, pc, rs1_data, rs2_data;
   logic        ready, done, branch_taken, fault, alu_available;
   logic [31:0] result, branch_target, alu_in_a, alu_in_b;
   logic [4:0]  alu_op;
   logic [31:0] alu_out;
   logic        alu_busy, alu_fault;

   int n_chk = 0;
   int n_fail = 0;
   int unsigned cyc = 0;

   alu_dispatch #(.TIMEOUT_CYCLES(TO)) dut (
      .clk           (clk),
      .reset         (reset),
      .start         (start),
      .ready         (ready),
      .instr         (instr),
      .pc            (pc),
      .rs1_data      (rs1_data),
      .rs2_data      (rs2_data),
      .done          (done),
      .result        (result),
      .branch_taken  (branch_taken),
      .branch_target (branch_target),
      .fault         (fault),
      .alu_available (alu_available),
      .alu_op        (alu_op),
      .alu_in_a      (alu_in_a),
      .alu_in_b      (alu_in_b),
      .alu_out       (alu_out),
      .alu_busy      (alu_busy),
      .alu_fault     (alu_fault)
   );

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   function automatic logic [31:0] alu_fn(input logic [4:0] op, input logic [31:0] a, b);
      case (op)
         5'b00000: return a + b;
         5'b01000: return a - b;
         5'b00001: return a << b[4:0];
         5'b00010: return {31'd0, $signed(a) < $signed(b)};
         5'b00011: return {31'd0, a < b};
         5'b00100: return a ^ b;
         5'b00101: return a >> b[4:0];
         5'b01101: return $signed(a) >>> b[4:0];
         5'b00110: return a | b;
         5'b00111: return a & b;
         5'b10000: return {31'd0, a == b};
         5'b10001: return {31'd0, a != b};
         5'b10100: return {31'd0, $signed(a) < $signed(b)};
         5'b10101: return {31'd0, $signed(a) >= $signed(b)};
         5'b10110: return {31'd0, a < b};
         5'b10111: return {31'd0, a >= b};
         default:  return 32'd0;
      endcase
   endfunction

   // Behavioural ALU: busy for alu_len cycles after first seeing available.
   int   alu_len = 1;
   bit   alu_stuck = 0, alu_ferr = 0;
   bit   a_started = 0;
   int   a_rem = 0;
   logic a_busy = 1'b0, a_flt = 1'b0;
   logic [31:0] a_out = '0;
   assign alu_busy  = a_busy;
   assign alu_fault = a_flt;
   assign alu_out   = a_out;

   always @(posedge clk) begin
      if (!alu_available) begin
         a_started <= 0;
         a_busy    <= 1'b0;
         a_flt     <= 1'b0;
      end else if (!a_started) begin
         if (!alu_stuck) begin
            a_started <= 1;
            a_busy    <= 1'b1;
            a_rem     <= alu_len - 1;
            a_out     <= alu_fn(alu_op, alu_in_a, alu_in_b);
            a_flt     <= alu_ferr;
         end
      end else if (a_rem > 0) begin
         a_rem <= a_rem - 1;
      end else begin
         a_busy <= 1'b0;
      end
   end

   // Instruction-level model of what the dispatcher must produce.
   function automatic void model(input logic [31:0] ins, p, a, b, output bit ill,
                                 output logic [4:0] op, output logic [31:0] bop, res, tgt,
                                 output bit tk);
      logic [6:0] opc, f7;
      logic [2:0] f3;
      logic [31:0] iimm, bimm, r;
      opc  = ins[6:0];
      f3   = ins[14:12];
      f7   = ins[31:25];
      iimm = {{20{ins[31]}}, ins[31:20]};
      bimm = {{20{ins[31]}}, ins[7], ins[30:25], ins[11:8], 1'b0};
      tgt  = p + bimm;
      op   = 5'd0;
      bop  = b;
      tk   = 0;
      if (opc == 7'b0110011) begin
         ill = !(f7 == 7'h00 || (f7 == 7'h20 && (f3 == 3'd0 || f3 == 3'd5)));
         op  = {1'b0, ins[30], f3};
      end else if (opc == 7'b0010011) begin
         bop = iimm;
         op  = {1'b0, (f3 == 3'd5) ? ins[30] : 1'b0, f3};
         ill = (f3 == 3'd1 && f7 != 7'h00) || (f3 == 3'd5 && !(f7 == 7'h00 || f7 == 7'h20));
      end else if (opc == 7'b1100011) begin
         op  = {2'b10, f3};
         ill = (f3 == 3'd2 || f3 == 3'd3);
      end else begin
         ill = 1;
      end
      r = alu_fn(op, a, bop);
      if (op[4]) begin
         tk  = r[0];
         res = '0;
      end else begin
         res = r;
      end
   endfunction

   bit          m_active = 0, m_legal = 0;
   int unsigned m_k = 0, m_done = 0;
   logic [4:0]  m_op = '0;
   logic [31:0] m_a = '0, m_b = '0;
   logic [31:0] p_res = '0, p_tgt = '0, prev_res = '0, prev_tgt = '0;
   bit          p_tk = 0, p_flt = 0, prev_tk = 0, prev_flt = 0;

   logic        in_flight, exp_done, exp_avail, after_done, exp_tk, exp_flt;
   logic [31:0] exp_res, exp_tgt;
   assign in_flight  = m_active && (cyc >= m_k) && (cyc <= m_done);
   assign exp_done   = m_active && (cyc == m_done);
   assign exp_avail  = in_flight && m_legal && (cyc < m_done);
   assign after_done = m_active && (cyc >= m_done);
   assign exp_res    = after_done ? p_res : prev_res;
   assign exp_tgt    = after_done ? p_tgt : prev_tgt;
   assign exp_tk     = after_done ? p_tk  : prev_tk;
   assign exp_flt    = after_done ? p_flt : prev_flt;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_chk++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s @cyc %0d: got %h, expected %h", name, cyc, act, exp);
      end
   endtask

   always @(negedge clk) begin
      if (!reset) begin
         chk("ready", {31'd0, ready}, {31'd0, !in_flight});
         chk("done", {31'd0, done}, {31'd0, exp_done});
         chk("alu_available", {31'd0, alu_available}, {31'd0, exp_avail});
         chk("result", result, exp_res);
         chk("branch_taken", {31'd0, branch_taken}, {31'd0, exp_tk});
         chk("branch_target", branch_target, exp_tgt);
         chk("fault", {31'd0, fault}, {31'd0, exp_flt});
         if (exp_avail) begin
            chk("alu_op", {27'd0, alu_op}, {27'd0, m_op});
            chk("alu_in_a", alu_in_a, m_a);
            chk("alu_in_b", alu_in_b, m_b);
         end
      end
   end

   task automatic at_cycle(input int unsigned n);
      int guard = 0;
      @(negedge clk);
      while (cyc < n && guard < 2000) begin
         @(negedge clk);
         guard++;
      end
   endtask

   task automatic issue(input logic [31:0] ins, p, a, b, input int len, input bit stuck,
                        input bit ferr, input bit poke);
      bit ill, tk;
      logic [4:0] op;
      logic [31:0] bop, res, tgt;
      model(ins, p, a, b, ill, op, bop, res, tgt, tk);
      at_cycle(m_active ? m_done + 1 : 0);
      #2;
      instr = ins; pc = p; rs1_data = a; rs2_data = b; start = 1'b1;
      alu_len = len; alu_stuck = stuck; alu_ferr = ferr;
      if (m_active) begin
         prev_res = p_res; prev_tgt = p_tgt; prev_tk = p_tk; prev_flt = p_flt;
      end
      m_k     = cyc + 1;
      m_done  = ill ? m_k : (stuck ? m_k + TO : m_k + 2 + len);
      m_legal = !ill;
      m_op = op; m_a = a; m_b = bop;
      p_tgt = tgt;
      p_res = (ill || stuck) ? 32'd0 : res;
      p_tk  = (ill || stuck) ? 0 : tk;
      p_flt = ill || stuck || ferr;
      m_active = 1;
      @(posedge clk);
      #1;
      start = 1'b0;
      instr = 32'hDEADBEEF; pc = 32'hDEADBEEF; rs1_data = 32'hDEADBEEF; rs2_data = 32'hDEADBEEF;
      if (poke) begin
         @(negedge clk);
         #2;
         start = 1'b1;
         instr = 32'h00208033;
         @(posedge clk);
         #1;
         start = 1'b0;
      end
   endtask

   initial begin
      reset = 1'b1; start = 1'b0;
      instr = '0; pc = '0; rs1_data = '0; rs2_data = '0;
      #1;
      chk("rst_ready", {31'd0, ready}, 32'd1);
      chk("rst_done", {31'd0, done}, 32'd0);
      chk("rst_avail", {31'd0, alu_available}, 32'd0);
      chk("rst_result", result, 32'd0);
      repeat (2) @(negedge clk);
      #2 reset = 1'b0;

      // ADD x, 5 + 7
      issue(32'h00208033, 32'h0, 32'd5, 32'd7, 1, 0, 0, 0);
      at_cycle(m_k);
      chk("add_op_lit", {27'd0, alu_op}, 32'd0);
      at_cycle(m_k + 3);
      chk("add_done_lit", {31'd0, done}, 32'd1);
      chk("add_result_lit", result, 32'd12);
      chk("add_fault_lit", {31'd0, fault}, 32'd0);

      // SUB back-to-back, ALU reports a fault, start poked while busy
      issue(32'h40208033, 32'h0, 32'd5, 32'd7, 1, 0, 1, 1);
      at_cycle(m_done);
      chk("sub_result_lit", result, 32'hFFFFFFFE);
      chk("sub_fault_lit", {31'd0, fault}, 32'd1);

      // SRAI imm=0x404
      issue(32'h4040D093, 32'h0, 32'h80000000, 32'h0, 1, 0, 0, 0);
      at_cycle(m_k);
      chk("srai_op_lit", {27'd0, alu_op}, 32'b01101);
      chk("srai_b_lit", alu_in_b, 32'h404);
      at_cycle(m_done);
      chk("srai_result_lit", result, 32'hF8000000);

      // XORI with instr[30] set must not become a shift-style f7b5 op
      issue(32'h4000C093, 32'h0, 32'hFF, 32'h0, 1, 0, 0, 0);
      at_cycle(m_k);
      chk("xori_op_lit", {27'd0, alu_op}, 32'b00100);
      at_cycle(m_done);
      chk("xori_result_lit", result, 32'h4FF);

      // ADDI -1 with a longer ALU latency
      issue(32'hFFF08093, 32'h0, 32'd10, 32'h0, 3, 0, 0, 0);
      at_cycle(m_done);
      chk("addi_result_lit", result, 32'd9);

      // BLT -1 < 1, offset +16
      issue(32'h0020C863, 32'h100, 32'hFFFFFFFF, 32'd1, 1, 0, 0, 0);
      at_cycle(m_done);
      chk("blt_taken_lit", {31'd0, branch_taken}, 32'd1);
      chk("blt_target_lit", branch_target, 32'h110);
      chk("blt_result_lit", result, 32'd0);

      // BGEU 3 >= 5 false, offset -8 wraps below zero
      issue(32'hFE20FCE3, 32'h4, 32'd3, 32'd5, 1, 0, 0, 0);
      at_cycle(m_done);
      chk("bgeu_taken_lit", {31'd0, branch_taken}, 32'd0);
      chk("bgeu_target_lit", branch_target, 32'hFFFFFFFC);

      // Illegal OP funct7=0000001: done right after start, ALU untouched
      issue(32'h02208033, 32'h0, 32'd5, 32'd7, 1, 0, 0, 0);
      at_cycle(m_k);
      chk("mul_done_lit", {31'd0, done}, 32'd1);
      chk("mul_fault_lit", {31'd0, fault}, 32'd1);
      chk("mul_avail_lit", {31'd0, alu_available}, 32'd0);

      issue(32'h40109093, 32'h0, 32'd1, 32'd0, 1, 0, 0, 1);
      issue(32'h0020A063, 32'h0, 32'd1, 32'd2, 1, 0, 0, 0);
      issue(32'h00000000, 32'h0, 32'd1, 32'd2, 1, 0, 0, 0);

      // Reset while in WAIT
      issue(32'h00208033, 32'h0, 32'd1, 32'd2, 50, 0, 0, 0);
      at_cycle(m_k + 3);
      #2 reset = 1'b1;
      m_active = 0;
      prev_res = '0; prev_tgt = '0; prev_tk = 0; prev_flt = 0;
      p_res = '0; p_tgt = '0; p_tk = 0; p_flt = 0;
      #1;
      chk("rstw_avail_lit", {31'd0, alu_available}, 32'd0);
      chk("rstw_ready_lit", {31'd0, ready}, 32'd1);
      @(negedge clk);
      #2 reset = 1'b0;

      issue(32'h00208033, 32'h0, 32'd20, 32'd22, 1, 0, 0, 0);
      at_cycle(m_done);
      chk("post_rst_result_lit", result, 32'd42);

`ifdef ALU_DISPATCH_TIMEOUT_EN
      issue(32'h00208033, 32'h0, 32'd1, 32'd2, 1, 1, 0, 0);
      at_cycle(m_k + 3);
      chk("to_not_yet_lit", {31'd0, done}, 32'd0);
      at_cycle(m_k + 4);
      chk("to_done_lit", {31'd0, done}, 32'd1);
      chk("to_fault_lit", {31'd0, fault}, 32'd1);
      chk("to_result_lit", result, 32'd0);
`endif

      at_cycle(m_done + 3);
      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end

endmodule
